// File: rtl/sd_cmd_tx_engine_pkg.sv
// Shared definitions for the SD command path: FSM encodings, frame geometry
// and a width-generic serial CRC step usable by both transmit and receive sides.
package sd_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [6:0] CRC7_POLY  = 7'h09;
    localparam int         NCC_MIN    = 8;
    localparam int         CRC_MAX_W  = 16;
    localparam int         CRC_IDX_W  = 4;

    function automatic int frame_len(input int idx_w, input int arg_w, input int crc_w);
        return 2 + idx_w + arg_w + crc_w + 1;
    endfunction

    // One data bit per call; bits at or above 'width' are always returned as zero.
    function automatic logic [CRC_MAX_W-1:0] crc_next(
        input logic [CRC_MAX_W-1:0] crc,
        input logic [CRC_MAX_W-1:0] poly,
        input logic                 data_bit,
        input int                   width
    );
        logic                 fb;
        logic [CRC_MAX_W-1:0] mask;
        logic [CRC_MAX_W-1:0] res;
        fb   = data_bit ^ crc[CRC_IDX_W'(width - 1)];
        mask = (CRC_MAX_W'(1) << width) - CRC_MAX_W'(1);
        res  = (crc << 1) ^ (fb ? poly : '0);
        return res & mask;
    endfunction

endpackage

// File: rtl/sd_cmd_tx_engine_if.sv
// Command request channel between the command FSM (master) and the TX engine (slave).
interface sd_cmd_tx_engine_if #(
    parameter int IDX_W = 6,
    parameter int ARG_W = 32
);
    // A request transfers on a clock edge where in_cmd_valid and out_cmd_ready are
    // both high; index and argument must be stable while valid is high and not ready.
    logic             in_cmd_valid;
    logic             out_cmd_ready;
    logic [IDX_W-1:0] in_command_index;
    logic [ARG_W-1:0] in_command_argument;

    modport master (
        output in_cmd_valid,
        output in_command_index,
        output in_command_argument,
        input  out_cmd_ready
    );

    modport slave (
        input  in_cmd_valid,
        input  in_command_index,
        input  in_command_argument,
        output out_cmd_ready
    );
endinterface

// File: rtl/sd_cmd_tx_engine_crc.sv
// Serial CRC accumulator, MSB-first, zero initial value; clr has priority over en.
module sd_crc_serial
    import sd_cmd_pkg::*;
#(
    parameter int           W    = 7,
    parameter logic [W-1:0] POLY = 7'h09
) (
    input  logic         in_sd_clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         data_bit,
    output logic [W-1:0] crc
);

    always_ff @(posedge in_sd_clk) begin
        if (rst || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= W'(crc_next(CRC_MAX_W'(crc), CRC_MAX_W'(POLY), data_bit, W));
        end
    end

endmodule

// File: rtl/sd_cmd_tx_engine.sv
// Host-side SD command transmitter: serialises start/transmit/index/argument/CRC/end
// bits, owns bus direction, abort handling and the post-frame NCC idle gap.
module sd_cmd_tx_engine
    import sd_cmd_pkg::*;
#(
    parameter int               IDX_W      = 6,
    parameter int               ARG_W      = 32,
    parameter int               CRC_W      = 7,
    parameter logic [CRC_W-1:0] CRC_POLY   = CRC7_POLY,
    parameter int               GAP_CYCLES = NCC_MIN
) (
    input  logic                in_sd_clk,
    input  logic                in_sd_rst,
    input  logic                in_soft_reset,
    sd_cmd_tx_engine_if.slave   cmd_if,
    input  logic                in_abort,
    input  logic                in_high_speed_clk,
    output logic                out_sd_cmd,
    output logic                out_cmd_dir,
    output logic                out_busy,
    output logic                out_done,
    output logic                out_aborted,
    output logic [7:0]          out_bit_cnt,
    output state_t              out_state
);

    localparam int          FRAME_LEN = frame_len(IDX_W, ARG_W, CRC_W);
    localparam int          DATA_LEN  = 2 + IDX_W + ARG_W;
    localparam int          SH_W      = DATA_LEN - 1;
    localparam logic [7:0]  LAST_CNT  = 8'(FRAME_LEN - 1);
    localparam logic [7:0]  DATA_CNT  = 8'(DATA_LEN);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 2);
    // The IDLE cycle before the next accept is itself the last idle gap clock.
    localparam state_t      GAP_ENTRY = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;

    logic             rst_any;
    logic             accept;
    state_t           state_q, state_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [7:0]       cnt_q, cnt_d, nxt_cnt;
    logic [7:0]       gap_q, gap_d;
    logic             cmd_q, cmd_d, dir_q, dir_d;
    logic             done_q, done_d, abt_q, abt_d;
    logic             cmd_n, dir_n;
    logic             crc_clr, crc_en;
    logic [CRC_W-1:0] crc_val;

    assign rst_any              = in_sd_rst || !in_soft_reset;
    assign cmd_if.out_cmd_ready = (state_q == ST_IDLE) && !rst_any;
    assign accept               = cmd_if.in_cmd_valid && cmd_if.out_cmd_ready;

    sd_crc_serial #(
        .W    (CRC_W),
        .POLY (CRC_POLY)
    ) u_crc (
        .in_sd_clk (in_sd_clk),
        .rst       (rst_any),
        .clr       (crc_clr),
        .en        (crc_en),
        .data_bit  (sh_q[SH_W-1]),
        .crc       (crc_val)
    );

    always_ff @(posedge in_sd_clk) begin
        if (rst_any) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            cmd_q   <= 1'b1;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            cmd_q   <= cmd_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            abt_q   <= abt_d;
        end
    end

    // The start bit is 0 and the CRC starts at 0, so feeding it is a no-op:
    // the CRC only sees bits 1..DATA_LEN-1 as they are loaded into cmd_q.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        cmd_d   = cmd_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        abt_d   = 1'b0;
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        nxt_cnt = cnt_q + 8'd1;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SEND;
                    sh_d    = {1'b1, cmd_if.in_command_index, cmd_if.in_command_argument};
                    cnt_d   = '0;
                    cmd_d   = 1'b0;
                    dir_d   = 1'b1;
                    crc_clr = 1'b1;
                end
            end
            ST_SEND: begin
                if (in_abort || cnt_q == LAST_CNT) begin
                    state_d = GAP_ENTRY;
                    cnt_d   = '0;
                    gap_d   = '0;
                    cmd_d   = 1'b1;
                    dir_d   = 1'b0;
                    abt_d   = in_abort;
                    done_d  = !in_abort;
                end else if (nxt_cnt == DATA_CNT) begin
                    // Reload the shifter with the CRC followed by the end bit.
                    cnt_d = nxt_cnt;
                    cmd_d = crc_val[CRC_W-1];
                    sh_d  = {crc_val[CRC_W-2:0], 1'b1, {(SH_W-CRC_W){1'b0}}};
                end else begin
                    cnt_d  = nxt_cnt;
                    cmd_d  = sh_q[SH_W-1];
                    sh_d   = sh_q << 1;
                    crc_en = (nxt_cnt < DATA_CNT);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Half-cycle delayed copy for low-speed cards; cmd and dir share one path.
    always_ff @(negedge in_sd_clk) begin
        if (rst_any) begin
            cmd_n <= 1'b1;
            dir_n <= 1'b0;
        end else begin
            cmd_n <= cmd_q;
            dir_n <= dir_q;
        end
    end

    assign out_sd_cmd  = in_high_speed_clk ? cmd_q : cmd_n;
    assign out_cmd_dir = in_high_speed_clk ? dir_q : dir_n;
    assign out_busy    = (state_q != ST_IDLE);
    assign out_done    = done_q;
    assign out_aborted = abt_q;
    assign out_bit_cnt = cnt_q;
    assign out_state   = state_q;

endmodule

// File: tb/tb_sd_cmd_tx_engine.sv
// Directed bench for sd_cmd_tx_engine: default 48-bit instance plus a 32-bit,
// 3-cycle-gap instance; samples cmd/dir/status every half cycle after accept.
module tb_sd_cmd_tx_engine;
    import sd_cmd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sd_rst, soft_n, abort, hs;

    sd_cmd_tx_engine_if #(.IDX_W(6), .ARG_W(32)) if_a ();
    sd_cmd_tx_engine_if #(.IDX_W(6), .ARG_W(16)) if_b ();

    logic       a_cmd, a_dir, a_busy, a_done, a_abt;
    logic [7:0] a_cnt;
    state_t     a_state;
    logic       b_cmd, b_dir, b_busy, b_done, b_abt;
    logic [7:0] b_cnt;
    state_t     b_state;

    sd_cmd_tx_engine dut_a (
        .in_sd_clk         (clk),
        .in_sd_rst         (sd_rst),
        .in_soft_reset     (soft_n),
        .cmd_if            (if_a),
        .in_abort          (abort),
        .in_high_speed_clk (hs),
        .out_sd_cmd        (a_cmd),
        .out_cmd_dir       (a_dir),
        .out_busy          (a_busy),
        .out_done          (a_done),
        .out_aborted       (a_abt),
        .out_bit_cnt       (a_cnt),
        .out_state         (a_state)
    );

    sd_cmd_tx_engine #(.IDX_W(6), .ARG_W(16), .GAP_CYCLES(3)) dut_b (
        .in_sd_clk         (clk),
        .in_sd_rst         (sd_rst),
        .in_soft_reset     (soft_n),
        .cmd_if            (if_b),
        .in_abort          (abort),
        .in_high_speed_clk (hs),
        .out_sd_cmd        (b_cmd),
        .out_cmd_dir       (b_dir),
        .out_busy          (b_busy),
        .out_done          (b_done),
        .out_aborted       (b_abt),
        .out_bit_cnt       (b_cnt),
        .out_state         (b_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [47:0] exp_q[$];

    // Per-cycle samples after accept edge k: s_* at negedge+1 following edge k+i,
    // q_* at edge k+i plus 1.
    logic       s_cmd [0:127];
    logic       s_dir [0:127];
    logic       s_done[0:127];
    logic       s_abt [0:127];
    logic       s_rdy [0:127];
    logic [7:0] s_cnt [0:127];
    logic       q_cmd [0:127];
    logic       q_dir [0:127];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7_ref(input logic [63:0] bits, input int nbits);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int j = nbits - 1; j >= 0; j--) begin
            fb = bits[6'(j)] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] bits_from(input int kind, input int start, input int len);
        logic [47:0] f;
        f = '0;
        for (int j = 0; j < len; j++) begin
            f = {f[46:0], (kind == 0) ? s_cmd[start + j] : s_dir[start + j]};
        end
        return f;
    endfunction

    function automatic int pulses(input int kind, input int len);
        int c;
        c = 0;
        for (int j = 0; j < len; j++) begin
            if ((kind == 0) ? s_done[j] : s_abt[j]) c++;
        end
        return c;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? if_a.out_cmd_ready : if_b.out_cmd_ready;
    endfunction

    task automatic issue(input int sel, input logic [5:0] idx, input logic [31:0] arg);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        if (sel == 0) begin
            if_a.in_cmd_valid = 1'b1; if_a.in_command_index = idx; if_a.in_command_argument = arg;
        end else begin
            if_b.in_cmd_valid = 1'b1; if_b.in_command_index = idx; if_b.in_command_argument = arg[15:0];
        end
        for (int t = 0; t < 200; t++) begin
            #1;
            if (rdy(sel)) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic monitor(input int sel, input int n, input int abort_i, input int rst_i,
                           input int drop_i, input logic [5:0] nidx, input logic [31:0] narg);
        #1;
        q_cmd[0] = (sel == 0) ? a_cmd : b_cmd;
        q_dir[0] = (sel == 0) ? a_dir : b_dir;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            s_cmd[i]  = (sel == 0) ? a_cmd  : b_cmd;
            s_dir[i]  = (sel == 0) ? a_dir  : b_dir;
            s_done[i] = (sel == 0) ? a_done : b_done;
            s_abt[i]  = (sel == 0) ? a_abt  : b_abt;
            s_cnt[i]  = (sel == 0) ? a_cnt  : b_cnt;
            s_rdy[i]  = rdy(sel);
            abort  = (i == abort_i);
            soft_n = (i != rst_i);
            if (i == 0) begin
                if (sel == 0) begin
                    if_a.in_command_index = nidx; if_a.in_command_argument = narg;
                end else begin
                    if_b.in_command_index = nidx; if_b.in_command_argument = narg[15:0];
                end
            end
            if (i == drop_i) begin
                if (sel == 0) if_a.in_cmd_valid = 1'b0;
                else          if_b.in_cmd_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            q_cmd[i+1] = (sel == 0) ? a_cmd : b_cmd;
            q_dir[i+1] = (sel == 0) ? a_dir : b_dir;
        end
        abort  = 1'b0;
        soft_n = 1'b1;
    endtask

    initial begin : main
        logic [23:0] b_bits;
        logic [47:0] b_frame;

        // Clock/reset block
        sd_rst = 1'b1; soft_n = 1'b1; abort = 1'b0; hs = 1'b1;
        if_a.in_cmd_valid = 1'b0; if_a.in_command_index = '0; if_a.in_command_argument = '0;
        if_b.in_cmd_valid = 1'b0; if_b.in_command_index = '0; if_b.in_command_argument = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_cmd",   64'(a_cmd), 64'd1);
        check_eq("rst_dir",   64'(a_dir), 64'd0);
        check_eq("rst_ready", 64'(if_a.out_cmd_ready), 64'd0);
        check_eq("rst_busy",  64'(a_busy), 64'd0);
        check_eq("rst_cnt",   64'(a_cnt), 64'd0);
        check_eq("rst_state", 64'(a_state), 64'(ST_IDLE));
        sd_rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("ready_after_rst", 64'(if_a.out_cmd_ready), 64'd1);

        // CMD0 high speed; inputs scrambled right after accept
        exp_q.push_back(48'h40_00000000_95);
        issue(0, 6'd0, 32'h0);
        monitor(0, 58, -1, -1, 0, 6'h3F, 32'hDEADBEEF);
        check_eq("cmd0_frame", 64'(bits_from(0, 0, 48)), 64'(exp_q.pop_front()));
        check_eq("cmd0_dir",   64'(bits_from(1, 0, 48)), 64'hFFFF_FFFF_FFFF);
        check_eq("cmd0_cnt0",  64'(s_cnt[0]), 64'd0);
        check_eq("cmd0_cnt47", 64'(s_cnt[47]), 64'd47);
        check_eq("cmd0_done_early", 64'(s_done[47]), 64'd0);
        check_eq("cmd0_done",  64'({s_done[48], s_cmd[48], s_dir[48]}), 64'b110);
        check_eq("cmd0_done_once", 64'(pulses(0, 58)), 64'd1);
        check_eq("cmd0_ready_gap", 64'(s_rdy[54]), 64'd0);
        check_eq("cmd0_ready_back", 64'(s_rdy[55]), 64'd1);

        // CMD8 then CMD17 back-to-back with valid held high
        exp_q.push_back(48'h48_000001AA_87);
        exp_q.push_back(48'h51_00000000_55);
        issue(0, 6'd8, 32'h0000_01AA);
        monitor(0, 106, -1, -1, 56, 6'd17, 32'h0);
        check_eq("cmd8_frame",  64'(bits_from(0, 0, 48)), 64'(exp_q.pop_front()));
        check_eq("b2b_idle_gap", 64'(bits_from(0, 47, 10)), 64'h3FE);
        check_eq("cmd17_frame", 64'(bits_from(0, 56, 48)), 64'(exp_q.pop_front()));

        // CMD0 low speed: same bits, half a cycle later, dir aligned with cmd
        hs = 1'b0;
        exp_q.push_back(48'h40_00000000_95);
        issue(0, 6'd0, 32'h0);
        monitor(0, 58, -1, -1, 0, 6'h2A, 32'h5555_AAAA);
        check_eq("ls_frame",     64'(bits_from(0, 0, 48)), 64'(exp_q.pop_front()));
        check_eq("ls_start_late", 64'({q_cmd[0], q_dir[0]}), 64'b10);
        check_eq("ls_start",     64'({q_cmd[1], q_dir[1]}), 64'b01);
        check_eq("ls_end_late",  64'({q_cmd[48], q_dir[48]}), 64'b11);
        check_eq("ls_end",       64'({s_cmd[48], s_dir[48]}), 64'b10);
        hs = 1'b1;

        // Abort sampled at bit 20
        issue(0, 6'd17, 32'h1234_5678);
        monitor(0, 40, 20, -1, 0, 6'd0, 32'h0);
        check_eq("abt_cnt20", 64'(s_cnt[20]), 64'd20);
        check_eq("abt_lines", 64'({s_cmd[21], s_dir[21], s_abt[21]}), 64'b101);
        check_eq("abt_pulse_once", 64'(pulses(1, 40)), 64'd1);
        check_eq("abt_no_done", 64'(pulses(0, 40)), 64'd0);
        check_eq("abt_ready_gap", 64'(s_rdy[27]), 64'd0);
        check_eq("abt_ready_back", 64'(s_rdy[28]), 64'd1);

        // Abort sampled at the final edge wins over done
        issue(0, 6'd0, 32'h0);
        monitor(0, 58, 47, -1, 0, 6'd0, 32'h0);
        check_eq("abt_last", 64'({s_abt[48], s_done[48], s_cmd[48]}), 64'b101);
        check_eq("abt_last_no_done", 64'(pulses(0, 58)), 64'd0);

        // Soft reset at bit 30
        issue(0, 6'd8, 32'h0000_01AA);
        monitor(0, 40, -1, 30, 0, 6'd0, 32'h0);
        check_eq("srst_cnt30", 64'(s_cnt[30]), 64'd30);
        check_eq("srst_lines", 64'({s_cmd[31], s_dir[31], s_rdy[31], s_cnt[31]}), 64'({3'b100, 8'd0}));
        check_eq("srst_ready", 64'(s_rdy[32]), 64'd1);
        check_eq("srst_no_pulse", 64'(pulses(0, 40) + pulses(1, 40)), 64'd0);

        // Non-default instance: 32-bit frame, 3-cycle gap
        b_bits  = {2'b01, 6'h11, 16'h1234};
        b_frame = 48'({b_bits, crc7_ref(64'(b_bits), 24), 1'b1});
        exp_q.push_back(b_frame);
        issue(1, 6'h11, 32'h0000_1234);
        monitor(1, 36, -1, -1, 0, 6'h3F, 32'hFFFF_FFFF);
        check_eq("b_frame", 64'(bits_from(0, 0, 32)), 64'(exp_q.pop_front()));
        check_eq("b_done", 64'({s_done[31], s_done[32]}), 64'b01);
        check_eq("b_ready_gap", 64'(s_rdy[33]), 64'd0);
        check_eq("b_ready_back", 64'(s_rdy[34]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_cmd_tx_engine.md
Name: sd_cmd_tx_engine

Overview:
Parametrised host-side SD command transmitter with valid/ready handshake. It owns the bit counter, frame sequencing, serial CRC generation, bus direction, abort and the mandatory NCC idle gap. It replaces the externally sequenced command send shift register in the command path. It feeds the CMD pad mux and reports completion to the command FSM.

Parameters:
IDX_W, 6, command index width
ARG_W, 32, command argument width
CRC_W, 7, CRC width
CRC_POLY, 7'h09, CRC polynomial without the x^CRC_W term (x^7+x^3+1)
GAP_CYCLES, 8, idle clocks (cmd=1, dir=0) forced after each frame or abort; legal range 1..255

Ports:
in_sd_clk  input  1  SD card clock; the only clock
in_sd_rst  input  1  synchronous, active-high reset
in_soft_reset  input  1  software reset, active-low, synchronous; same effect as in_sd_rst
in_cmd_valid  input  1  command request
out_cmd_ready  output  1  engine can accept a command
in_command_index  input  IDX_W  command index
in_command_argument  input  ARG_W  command argument
in_abort  input  1  abort current frame
in_high_speed_clk  input  1  1: drive on posedge; 0: posedge value re-registered on negedge
out_sd_cmd  output  1  serial CMD line
out_cmd_dir  output  1  1 = host drives, 0 = receive
out_busy  output  1  state is not IDLE
out_done  output  1  one-cycle pulse when a frame completes normally
out_aborted  output  1  one-cycle pulse when a frame is aborted
out_bit_cnt  output  8  index of the bit currently driven (0..FRAME_LEN-1)

Behaviour:
- Frame layout: FRAME_LEN = 2 + IDX_W + ARG_W + CRC_W + 1 (48 by default). Bits are sent MSB first in this order: start bit 0, transmit bit 1, index, argument, CRC, end bit 1.
- CRC:
  - Computed over the first 2+IDX_W+ARG_W bits, initial value 0.
  - Feedback = data_bit ^ crc[msb]. Each bit set in CRC_POLY XORs the feedback into that position.
  - Implementation may be serial or parallel; only the wire value is specified.
- Reset (in_sd_rst=1 or in_soft_reset=0): state=IDLE, out_sd_cmd=1, out_cmd_dir=0, out_busy=0, out_done=0, out_aborted=0, out_bit_cnt=0.
  - out_cmd_ready=0 while reset is asserted, and 1 the cycle after reset is released.
  - The negedge copies of cmd and dir reset to 1 and 0.
- States:
  - IDLE: out_cmd_ready=1.
  - SEND: drives frame bits.
  - GAP: counts GAP_CYCLES.
  - Encoding lives in the package.
- Accept: at edge k with valid&ready, index and argument are captured into the shift register. After edge k: out_sd_cmd=0 (start bit), out_cmd_dir=1, out_bit_cnt=0, state=SEND.
  - Input changes after edge k are ignored.
- SEND: at edge k+n, out_bit_cnt=n and frame bit n is driven, for n=1..FRAME_LEN-1.
- End of frame: at edge k+FRAME_LEN: out_sd_cmd=1, out_cmd_dir=0, out_done=1 for one cycle, state=GAP.
- GAP: lasts GAP_CYCLES cycles with out_cmd_ready=0. The next accept is possible at edge k+FRAME_LEN+GAP_CYCLES.
  - in_cmd_valid is ignored during SEND and GAP.
- Abort: in_abort=1 sampled in SEND at edge j gives, after edge j: out_sd_cmd=1, out_cmd_dir=0, out_aborted=1 for one cycle, out_done=0, state=GAP (full gap).
  - in_abort in IDLE or GAP is ignored.
  - Abort sampled at the same edge as the final bit transition (edge k+FRAME_LEN): abort wins, so out_done=0 and out_aborted=1.
- Output mux: in_high_speed_clk=1 selects the posedge register. in_high_speed_clk=0 selects the negedge copy, delayed half a cycle.
  - Direction uses the same mux, so cmd and dir stay aligned.
  - in_high_speed_clk may change only while IDLE.
- Reset mid-frame: the next edge forces reset values. No done or aborted pulse is generated.

Decomposition:
- sd_cmd_pkg contains:
  - state encodings: ST_IDLE, ST_SEND, ST_GAP
  - frame_len function
  - crc_next function (CRC_POLY-generic, one bit per call)
  - default constants CRC7_POLY=7'h09 and NCC_MIN=8
- One sub-module: sd_crc_serial (parametrised width/poly, with clr, en and data_bit inputs, output crc). It is reusable later by the response checker.

Test Plan:
- CMD0, arg 0x00000000, high speed -> wire 0x40_00000000_95 (CRC 0x4A); out_done at edge k+48; out_cmd_ready returns at k+56.
- CMD8, arg 0x000001AA -> wire 0x48_000001AA_87 (CRC 0x43); CMD17, arg 0 -> 0x51_00000000_55 (CRC 0x2A), issued back-to-back with valid held high -> the second start bit appears exactly 8 idle cycles after the first end bit.
- in_high_speed_clk=0, CMD0 -> same bit sequence on the wire, shifted half a cycle; dir rises and falls aligned with cmd.
- in_abort at out_bit_cnt=20 -> cmd=1 and dir=0 the next cycle, out_aborted pulse, no out_done, ready after 8 cycles. Also abort at the final edge -> out_aborted only.
- in_soft_reset=0 at bit 30 -> cmd=1, dir=0, ready the cycle after release. Index and argument changed after accept -> the frame is unaffected.
- Non-default parameters (IDX_W=6, ARG_W=16, GAP_CYCLES=3) -> 32-bit frame with CRC matching the reference model; 3-cycle gap.
